// File: rtl/cache_ctrl_mp_pkg.sv
// Shared types for the multi-port L1 miss/refill controller.
package cache_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WB_RD,
    WB_WR,
    FETCH,
    FILL
  } state_t;

  // Line-buffer data-path direction codes.
  localparam logic [1:0] CL_UNUSED = 2'b00;
  localparam logic [1:0] CL_SRC_L1 = 2'b11;
  localparam logic [1:0] CL_TO_MM  = 2'b01;
  localparam logic [1:0] CL_SRC_MM = 2'b10;

endpackage

// File: rtl/cache_ctrl_mp_rr_arbiter.sv
// Round-robin picker: index of the first requesting port at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt,
  output logic          any
);

  // Scan from the farthest candidate back to ptr so the nearest request wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    gnt = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        gnt = PW'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_ctrl_mp.sv
// Multi-port L1 miss/refill controller: one shared line buffer, one MM port, round-robin misses.
module cache_ctrl_mp
  import cache_pkg::*;
#(
  parameter int                  N_PORTS        = 2,
  parameter int                  WORDS_PER_LINE = 4,
  parameter logic [N_PORTS-1:0]  WB_MASK        = 2'b10,
  parameter int                  PW             = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  parameter int                  CW             = $clog2(WORDS_PER_LINE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PORTS-1:0] re,
  input  logic [N_PORTS-1:0] we,
  input  logic [N_PORTS-1:0] hit,
  input  logic [N_PORTS-1:0] dirty,
  input  logic               mem_valid_mm,
  output logic               clr,
  output logic [N_PORTS-1:0] mem_valid,
  output logic [PW-1:0]      grant,
  output logic               busy,
  output logic [1:0]         cl_dir_sel,
  output logic [CW-1:0]      cl_idx,
  output logic               we_cl,
  output logic [N_PORTS-1:0] we_l1,
  output logic               re_mm,
  output logic               we_data_mm,
  output logic               reset_mm
);

  state_t             r_state, w_next_state;
  logic [CW-1:0]      r_cl_idx, w_next_idx;
  logic [PW-1:0]      r_grant, w_next_grant;
  logic [PW-1:0]      r_rr_ptr, w_next_rr;

  logic [N_PORTS-1:0] w_active, w_miss, w_grant_oh;
  logic [PW-1:0]      w_arb_gnt;
  logic               w_arb_any, w_last;

  assign w_active   = re | (we & WB_MASK);
  assign w_miss     = w_active & ~hit;
  assign w_grant_oh = N_PORTS'(1) << r_grant;
  assign w_last     = (r_cl_idx == CW'(WORDS_PER_LINE - 1));

  rr_arbiter #(.N(N_PORTS), .PW(PW)) u_arb (
    .req (w_miss),
    .ptr (r_rr_ptr),
    .gnt (w_arb_gnt),
    .any (w_arb_any)
  );

  // The port owning the line buffer is acked only through the refill path, never as a hit.
  always_comb begin
    mem_valid = w_active & hit;
    if (r_state == INIT) mem_valid = '0;
    else if (r_state != IDLE) mem_valid = mem_valid & ~w_grant_oh;
  end

  assign busy   = (r_state != INIT) && (r_state != IDLE);
  assign grant  = r_grant;
  assign cl_idx = r_cl_idx;

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_cl_idx;
    w_next_grant = r_grant;
    w_next_rr    = r_rr_ptr;
    clr          = 1'b0;
    cl_dir_sel   = CL_UNUSED;
    we_cl        = 1'b0;
    we_l1        = '0;
    re_mm        = 1'b0;
    we_data_mm   = 1'b0;
    reset_mm     = 1'b0;
    case (r_state)
      INIT: begin
        clr          = 1'b1;
        w_next_idx   = '0;
        w_next_state = IDLE;
      end
      IDLE: begin
        if (w_arb_any) begin
          w_next_grant = w_arb_gnt;
          reset_mm     = 1'b1;
          w_next_idx   = '0;
          w_next_state = (WB_MASK[w_arb_gnt] && dirty[w_arb_gnt]) ? WB_RD : FETCH;
        end
      end
      WB_RD: begin
        cl_dir_sel = CL_SRC_L1;
        we_cl      = 1'b1;
        w_next_idx = r_cl_idx + 1'b1;
        if (w_last) w_next_state = WB_WR;
      end
      WB_WR: begin
        cl_dir_sel = CL_TO_MM;
        we_data_mm = 1'b1;
        if (mem_valid_mm) begin
          w_next_idx = r_cl_idx + 1'b1;
          if (w_last) begin
            reset_mm     = 1'b1;
            w_next_state = FETCH;
          end
        end
      end
      FETCH: begin
        cl_dir_sel = CL_SRC_MM;
        re_mm      = 1'b1;
        we_cl      = mem_valid_mm;
        if (mem_valid_mm) begin
          w_next_idx = r_cl_idx + 1'b1;
          if (w_last) w_next_state = FILL;
        end
      end
      FILL: begin
        cl_dir_sel = CL_SRC_MM;
        we_l1      = w_grant_oh;
        w_next_idx = r_cl_idx + 1'b1;
        if (w_last) begin
          reset_mm     = 1'b1;
          w_next_rr    = (r_grant == PW'(N_PORTS - 1)) ? '0 : r_grant + 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_idx   = '0;
        w_next_state = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= INIT;
      r_cl_idx <= '0;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same clock edge.
      r_state  <= w_next_state;
      r_cl_idx <= w_next_idx;
      r_grant  <= w_next_grant;
      r_rr_ptr <= w_next_rr;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_mp.sv
// Randomized bench for cache_ctrl_mp against a word-count based transaction model.
module tb_cache_ctrl_mp;

  localparam int         N   = 2;
  localparam int         W   = 4;
  localparam logic [1:0] WBM = 2'b10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] re = '0, we = '0, hit = '0, dirty = '0;
  logic       mem_valid_mm = 1'b0;
  logic       clr, busy, we_cl, re_mm, we_data_mm, reset_mm;
  logic [1:0] mem_valid, we_l1, cl_dir_sel, cl_idx;
  logic [0:0] grant;

  always #5 clk = ~clk;

  cache_ctrl_mp #(.N_PORTS(N), .WORDS_PER_LINE(W), .WB_MASK(WBM)) dut (
    .clk(clk), .reset(reset), .re(re), .we(we), .hit(hit), .dirty(dirty),
    .mem_valid_mm(mem_valid_mm), .clr(clr), .mem_valid(mem_valid), .grant(grant),
    .busy(busy), .cl_dir_sel(cl_dir_sel), .cl_idx(cl_idx), .we_cl(we_cl),
    .we_l1(we_l1), .re_mm(re_mm), .we_data_mm(we_data_mm), .reset_mm(reset_mm)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: a miss service is a count of words read from L1, written to MM,
  // fetched from MM and filled into L1; the phase follows from which count is incomplete.
  bit m_init, m_busy, m_dl;
  int m_port, m_grant, m_rr, n_rd, n_wr, n_fetch, n_fill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_busy = 0; m_dl = 0;
    m_port = 0; m_grant = 0; m_rr = 0;
    n_rd = 0; n_wr = 0; n_fetch = 0; n_fill = 0;
  endtask

  task automatic run_cycle(input logic [1:0] i_re, input logic [1:0] i_we,
                           input logic [1:0] i_hit, input logic [1:0] i_dirty,
                           input logic i_mv, input logic i_rst);
    int ph, pk, e_idx;
    logic [1:0] act, miss, e_mv, e_wl1, e_dir;
    logic e_wecl, e_rst_mm;
    @(negedge clk);
    cyc++;
    re = i_re; we = i_we; hit = i_hit; dirty = i_dirty;
    mem_valid_mm = i_mv; reset = i_rst;
    if (i_rst) model_reset();
    #1;
    act  = i_re | (i_we & WBM);
    miss = act & ~i_hit;
    if (m_init) ph = 0;
    else if (!m_busy) ph = 1;
    else if (m_dl && n_rd < W) ph = 2;
    else if (m_dl && n_wr < W) ph = 3;
    else if (n_fetch < W) ph = 4;
    else ph = 5;
    pk = -1;
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_rr + k) % N;
      if (pk < 0 && miss[p]) pk = p;
    end
    e_mv = act & i_hit;
    if (ph == 0) e_mv = '0;
    else if (ph >= 2) e_mv[m_port] = 1'b0;
    case (ph)
      2: begin e_idx = n_rd;    e_dir = 2'b11; end
      3: begin e_idx = n_wr;    e_dir = 2'b01; end
      4: begin e_idx = n_fetch; e_dir = 2'b10; end
      5: begin e_idx = n_fill;  e_dir = 2'b10; end
      default: begin e_idx = 0; e_dir = 2'b00; end
    endcase
    e_wecl   = (ph == 2) || (ph == 4 && i_mv);
    e_wl1    = (ph == 5) ? (2'b01 << m_port) : 2'b00;
    e_rst_mm = (ph == 1 && pk >= 0) || (ph == 3 && n_wr == W - 1 && i_mv) ||
               (ph == 5 && n_fill == W - 1);
    check("clr",        32'(clr),        32'(ph == 0));
    check("busy",       32'(busy),       32'(ph >= 2));
    check("grant",      32'(grant),      32'(m_grant));
    check("cl_dir_sel", 32'(cl_dir_sel), 32'(e_dir));
    check("cl_idx",     32'(cl_idx),     32'(e_idx));
    check("we_cl",      32'(we_cl),      32'(e_wecl));
    check("we_l1",      32'(we_l1),      32'(e_wl1));
    check("re_mm",      32'(re_mm),      32'(ph == 4));
    check("we_data_mm", 32'(we_data_mm), 32'(ph == 3));
    check("reset_mm",   32'(reset_mm),   32'(e_rst_mm));
    check("mem_valid",  32'(mem_valid),  32'(e_mv));
    if (!i_rst) begin
      case (ph)
        0: m_init = 0;
        1: if (pk >= 0) begin
             m_busy = 1; m_port = pk; m_grant = pk;
             m_dl = WBM[pk] && i_dirty[pk];
             n_rd = 0; n_wr = 0; n_fetch = 0; n_fill = 0;
           end
        2: n_rd++;
        3: if (i_mv) n_wr++;
        4: if (i_mv) n_fetch++;
        default: begin
          n_fill++;
          if (n_fill == W) begin
            m_busy = 0;
            m_rr = (m_port + 1) % N;
          end
        end
      endcase
    end
  endtask

  initial begin
    bit reached;
    model_reset();
    run_cycle('0, '0, '0, '0, 1'b0, 1'b1);
    run_cycle('0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) run_cycle('0, '0, '0, '0, 1'b1, 1'b0);
    run_cycle(2'b11, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    // Port 0 read-only miss with MM answering every second cycle.
    for (int i = 0; i < 30; i++) run_cycle(2'b01, 2'b00, 2'b00, 2'b00, 1'(i % 2), 1'b0);
    // Port 1 dirty miss, then both ports missing continuously with port 0 hit probes.
    for (int i = 0; i < 30; i++) run_cycle(2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 80; i++)
      run_cycle(2'b11, 2'b00, {1'b0, 1'(i % 3 == 0)}, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 2000; i++)
      run_cycle(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                1'($urandom_range(0, 1)), $urandom_range(0, 249) == 0);
    // Reset in the middle of write-back word 2 must stop MM traffic immediately.
    run_cycle('0, '0, '0, '0, 1'b0, 1'b1);
    reached = 0;
    for (int i = 0; i < 50 && !reached; i++) begin
      run_cycle(2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0);
      reached = m_busy && m_dl && n_rd == W && n_wr == 2;
    end
    check("wbwr_reach", 32'(reached), 32'd1);
    run_cycle(2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) run_cycle('0, '0, '0, '0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
